// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: operation codes, FSM state type and width default shared by the
// EX-stage ALU and the ALU controller.                             Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLLV = 4'b1000;
  localparam logic [3:0] OP_ORI  = 4'b1011;
  localparam logic [3:0] OP_LUI  = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_alu_unit_if.sv
// ---------------------------------------------------------------------------
// ex_alu_unit_if: operation request and result bus of the EX-stage ALU.
//                                                                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_alu_unit_if #(
  parameter int DATA_W  = alu_pkg::DATA_W_DEF,
  parameter int SHAMT_W = 5
);
  logic               start_i;
  logic [3:0]         ALUCtrl_i;
  logic [DATA_W-1:0]  src1_i;
  logic [DATA_W-1:0]  src2_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [DATA_W-1:0]  result_o;
  logic               zero_o;
  logic               overflow_o;
  logic               done_o;
  logic               busy_o;

  modport master (
    output start_i, ALUCtrl_i, src1_i, src2_i, shamt_i,
    input  result_o, zero_o, overflow_o, done_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, src1_i, src2_i, shamt_i,
    output result_o, zero_o, overflow_o, done_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter: one-bit-per-step left shift register with down-counter.
//                                                                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  input  wire logic               load_i,
  input  wire logic               step_i,
  input  wire logic [DATA_W-1:0]  data_i,
  input  wire logic [SHAMT_W-1:0] amt_i,
  output logic      [DATA_W-1:0]  data_o,
  output logic                    last_o
);

  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  // data_o is the value the register holds after the current step
  assign data_o = {shreg_q[DATA_W-2:0], 1'b0};
  assign last_o = (cnt_q == SHAMT_W'(1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = amt_i;
    end else if (step_i) begin
      shreg_d = data_o;
      cnt_d   = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_alu_unit.sv
// ---------------------------------------------------------------------------
// ex_alu_unit: EX-stage ALU, single-cycle arith/logic, iterative shifts
// (single-cycle barrel shift when EX_ALU_BARREL_SHIFT_EN).         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = 5
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  ex_alu_unit_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   sum, diff, alu_res;
  logic                alu_ovf;
  logic                is_shift;
  logic [SHAMT_W-1:0]  amt;

  assign sum      = bus.src1_i + bus.src2_i;
  assign diff     = bus.src1_i - bus.src2_i;
  assign is_shift = (bus.ALUCtrl_i == OP_SLL) || (bus.ALUCtrl_i == OP_SLLV);
  assign amt      = (bus.ALUCtrl_i == OP_SLL) ? bus.shamt_i : bus.src1_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUCtrl_i)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.src1_i[MSB] == bus.src2_i[MSB]) && (sum[MSB] != bus.src1_i[MSB]);
      end
      OP_SUB, OP_BEQ: begin
        alu_res = diff;
        alu_ovf = (bus.src1_i[MSB] != bus.src2_i[MSB]) && (diff[MSB] != bus.src1_i[MSB]);
      end
      OP_AND:        alu_res = bus.src1_i & bus.src2_i;
      OP_OR, OP_ORI: alu_res = bus.src1_i | bus.src2_i;
      OP_SLT:        alu_res = {{MSB{1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_SLTU:       alu_res = {{MSB{1'b0}}, (bus.src1_i < bus.src2_i)};
      OP_LUI:        alu_res = bus.src2_i << 16;
      default:       alu_res = '0;
    endcase
  end

`ifndef EX_ALU_BARREL_SHIFT_EN
  logic              sh_load, sh_step, sh_last;
  logic [DATA_W-1:0] sh_data;

  alu_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (sh_load),
    .step_i (sh_step),
    .data_i (bus.src2_i),
    .amt_i  (amt),
    .data_o (sh_data),
    .last_o (sh_last)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
`ifndef EX_ALU_BARREL_SHIFT_EN
    sh_load  = 1'b0;
    sh_step  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          done_d = 1'b1;
          if (is_shift) begin
`ifdef EX_ALU_BARREL_SHIFT_EN
            result_d = bus.src2_i << amt;
            ovf_d    = 1'b0;
`else
            if (amt == '0) begin
              result_d = bus.src2_i;
              ovf_d    = 1'b0;
            end else begin
              sh_load = 1'b1;
              done_d  = 1'b0;
              state_d = ST_SHIFT;
            end
`endif
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
          end
        end
      end
      ST_SHIFT: begin
`ifdef EX_ALU_BARREL_SHIFT_EN
        state_d = ST_IDLE;
`else
        sh_step = 1'b1;
        if (sh_last) begin
          result_d = sh_data;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // zero flag tracks whatever result is being committed this edge
    if (done_d) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
  assign bus.done_o     = done_q;
`ifdef EX_ALU_BARREL_SHIFT_EN
  assign bus.busy_o     = 1'b0;
`else
  assign bus.busy_o     = (state_q == ST_SHIFT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_unit: directed vectors against a latency-aware reference model.
//                                                                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_alu_unit;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_alu_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  ex_alu_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

`ifdef EX_ALU_BARREL_SHIFT_EN
  localparam int SLL31_BUSY = 0;
`else
  localparam int SLL31_BUSY = 31;
`endif

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  typedef struct packed {
    logic [31:0] r;
    logic        v;
    logic [5:0]  lat;
  } mres_t;

  // Reference: result from signed/unsigned integer arithmetic, latency = shift amount
  function automatic mres_t model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh);
    mres_t  m;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = '0;
    case (op)
      OP_ADD: begin
        t = sa + sb; m.r = t[31:0];
        m.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_SUB, OP_BEQ: begin
        t = sa - sb; m.r = t[31:0];
        m.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_AND:        m.r = a & b;
      OP_OR, OP_ORI: m.r = a | b;
      OP_SLT:        m.r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:       m.r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  begin m.r = b << sh;     m.lat = {1'b0, sh};     end
      OP_SLLV: begin m.r = b << a[4:0]; m.lat = {1'b0, a[4:0]}; end
      OP_LUI:        m.r = {b[15:0], 16'h0000};
      default:       m.r = 32'h0;
    endcase
`ifdef EX_ALU_BARREL_SHIFT_EN
    m.lat = '0;
`endif
    return m;
  endfunction

  mres_t c;
  assign c = model_op(bus.ALUCtrl_i, bus.src1_i, bus.src2_i, bus.shamt_i);

  int          cyc, done_at;
  logic        m_busy, m_done, m_zero, m_ovf, p_ovf;
  logic [31:0] m_res, p_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; done_at <= 0;
      m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0; m_ovf <= 1'b0;
      m_res <= '0; p_res <= '0; p_ovf <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_busy) begin
        if (cyc + 1 == done_at) begin
          m_res <= p_res; m_ovf <= p_ovf; m_zero <= (p_res == 0);
          m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (bus.start_i) begin
        if (c.lat == 0) begin
          m_res <= c.r; m_ovf <= c.v; m_zero <= (c.r == 0); m_done <= 1'b1;
        end else begin
          p_res <= c.r; p_ovf <= c.v; done_at <= cyc + 1 + int'(c.lat); m_busy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("done_o",     {31'b0, bus.done_o},     {31'b0, m_done});
    check("busy_o",     {31'b0, bus.busy_o},     {31'b0, m_busy});
    check("result_o",   bus.result_o,            m_res);
    check("zero_o",     {31'b0, bus.zero_o},     {31'b0, m_zero});
    check("overflow_o", {31'b0, bus.overflow_o}, {31'b0, m_ovf});
  end

  int busy_cnt = 0;
  always @(negedge clk) if (bus.busy_o) busy_cnt <= busy_cnt + 1;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.ALUCtrl_i = op; bus.src1_i = a; bus.src2_i = b; bus.shamt_i = sh;
    bus.start_i   = 1'b1;
    @(negedge clk);
    bus.start_i   = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !bus.done_o; i++) @(negedge clk);
    check("done_timeout", {31'b0, bus.done_o}, 32'd1);
  endtask

  task automatic run1(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic eo);
    drive(op, a, b, 5'd0);
    check({name, "_done"}, {31'b0, bus.done_o}, 32'd1);
    check(name, bus.result_o, er);
    check({name, "_ovf"}, {31'b0, bus.overflow_o}, {31'b0, eo});
  endtask

  int b0;
  logic seen_done;

  initial begin
    bus.start_i = 1'b0; bus.ALUCtrl_i = '0; bus.src1_i = '0; bus.src2_i = '0; bus.shamt_i = '0;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_zero",   {31'b0, bus.zero_o}, 32'd0);
    check("rst_done",   {31'b0, bus.done_o}, 32'd0);
    check("rst_busy",   {31'b0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run1("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1);
    run1("sub_zero", OP_SUB,  32'd5,         32'd5,         32'h0,         1'b0);
    check("sub_zero_flag", {31'b0, bus.zero_o}, 32'd1);
    run1("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0);
    run1("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0);
    run1("lui",      OP_LUI,  32'h0,         32'h1234,      32'h1234_0000, 1'b0);
    run1("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    run1("or",       OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    run1("ori",      OP_ORI,  32'h1234_0000, 32'h5678,      32'h1234_5678, 1'b0);
    run1("beq_ovf",  OP_BEQ,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1);
    run1("sub_neg",  OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0);
    run1("illegal",  4'b1001, 32'h1234,      32'h5678,      32'h0,         1'b0);

    b0 = busy_cnt;
    run1("sllv_amt0", OP_SLLV, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("sllv_amt0_busy", busy_cnt - b0, 32'd0);

    b0 = busy_cnt;
    drive(OP_SLL, 32'h0, 32'h1, 5'd31);
    if (bus.busy_o) begin
      @(negedge clk);
      drive(OP_ADD, 32'h1, 32'h1, 5'd0);
    end
    wait_done(40);
    check("sll31", bus.result_o, 32'h8000_0000);
    check("sll31_busy", busy_cnt - b0, SLL31_BUSY);

    drive(OP_SLL, 32'h0, 32'hF, 5'd3);
    wait_done(40);
    check("sll3", bus.result_o, 32'h78);
    drive(OP_ADD, 32'd2, 32'd3, 5'd0);
    check("b2b_done", {31'b0, bus.done_o}, 32'd1);
    check("b2b_add", bus.result_o, 32'd5);

    drive(OP_SLLV, 32'd20, 32'h3, 5'd0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result_o, 32'h0);
    check("midrst_zero",   {31'b0, bus.zero_o}, 32'd0);
    check("midrst_ovf",    {31'b0, bus.overflow_o}, 32'd0);
    check("midrst_busy",   {31'b0, bus.busy_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done_o) seen_done = 1'b1;
    end
    check("midrst_no_done", {31'b0, seen_done}, 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
